// File: rtl/led_flash_sched_if.sv
// Counter inputs and LED drive outputs of the LED flash scheduler.
interface led_flash_sched_if;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned CTR_W   = 4;
  localparam int unsigned COLOR_W = 3;

  logic [STATE_W-1:0] state;
  logic [CTR_W-1:0]   score;
  logic [CTR_W-1:0]   miss;
  logic [COLOR_W-1:0] tri_color1;
  logic [COLOR_W-1:0] tri_color2;
  logic               busy;
  logic               overflow;

  // Game-logic side: drives the counters and observes the LEDs.
  modport master (
    output state, score, miss,
    input  tri_color1, tri_color2, busy, overflow
  );

  // Scheduler side.
  modport slave (
    input  state, score, miss,
    output tri_color1, tri_color2, busy, overflow
  );
endinterface

// File: rtl/led_flash_sched.sv
// Queues score/miss counter changes and plays them as timed LED flashes
// separated by dark gaps, one request at a time.
module led_flash_sched #(
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 5000000,
  parameter logic [2:0]  PLAY_STATE  = 3'd2,
  parameter logic [2:0]  MISS_COLOR  = 3'b100,
  parameter logic [2:0]  SCORE_COLOR = 3'b011
) (
  input logic               clk,
  input logic               rst,
  led_flash_sched_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int unsigned QDEPTH     = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned QCNT_W     = 3;
  localparam int unsigned CTR_W      = 4;
  localparam int unsigned COLOR_W    = 3;

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_INIT  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLASH = 2'd1,
    GAP   = 2'd2
  } fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cur_type_q, cur_type_d;
  logic [COLOR_W-1:0] tc1_d, tc2_d;
  logic               pop;

  logic               primed;
  logic [CTR_W-1:0]   score_q, miss_q;
  logic               score_ev, miss_ev, in_play;
  logic               miss_push, score_push;

  logic [QDEPTH-1:0]  q_mem;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [QCNT_W-1:0]  q_count, q_count_d, free;
  logic [1:0]         req, acc;
  logic               slot0, slot1, drop;
  logic               head;

  // Edge detection on the counters; first edge after reset only primes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      primed  <= 1'b0;
      score_q <= '0;
      miss_q  <= '0;
    end else begin
      primed  <= 1'b1;
      score_q <= bus.score;
      miss_q  <= bus.miss;
    end
  end

  assign score_ev   = primed && (bus.score != score_q);
  assign miss_ev    = primed && (bus.miss != miss_q);
  assign in_play    = (bus.state == PLAY_STATE);
  assign miss_push  = in_play && miss_ev;
  assign score_push = in_play && score_ev;
  assign head       = q_mem[rd_ptr];

  // Push arbitration: miss ahead of score, space counted after this cycle's pop.
  always_comb begin
    req   = {1'b0, miss_push} + {1'b0, score_push};
    slot0 = ~miss_push;
    slot1 = 1'b1;
    free  = QCNT_W'(QDEPTH) - (q_count - {2'b00, pop});
    acc   = req;
    drop  = 1'b0;
    if ({1'b0, req} > free) begin
      acc  = free[1:0];
      drop = 1'b1;
    end
    q_count_d = q_count - {2'b00, pop} + {1'b0, acc};
  end

  // Request FIFO storage, pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_mem        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      q_count      <= '0;
      bus.overflow <= 1'b0;
    end else begin
      if (acc != 2'd0) q_mem[wr_ptr] <= slot0;
      if (acc == 2'd2) q_mem[wr_ptr + 2'd1] <= slot1;
      wr_ptr  <= wr_ptr + acc;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      q_count <= q_count_d;
      if (drop) bus.overflow <= 1'b1;
    end
  end

  // FSM state, timer and LED output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q          <= IDLE;
      cnt_q          <= '0;
      cur_type_q     <= 1'b0;
      bus.tri_color1 <= '0;
      bus.tri_color2 <= '0;
    end else begin
      fsm_q          <= fsm_d;
      cnt_q          <= cnt_d;
      cur_type_q     <= cur_type_d;
      bus.tri_color1 <= tc1_d;
      bus.tri_color2 <= tc2_d;
    end
  end

  // Next state, timer, pop request and next LED values.
  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    cur_type_d = cur_type_q;
    pop        = 1'b0;
    tc1_d      = '0;
    tc2_d      = '0;
    case (fsm_q)
      IDLE: begin
        if (q_count != '0) begin
          pop        = 1'b1;
          fsm_d      = FLASH;
          cnt_d      = HOLD_INIT;
          cur_type_d = head;
        end
      end
      FLASH: begin
        if (cnt_q == '0) begin
          fsm_d = GAP;
          cnt_d = GAP_INIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (q_count != '0) begin
            pop        = 1'b1;
            fsm_d      = FLASH;
            cnt_d      = HOLD_INIT;
            cur_type_d = head;
          end else begin
            fsm_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        fsm_d = IDLE;
        cnt_d = '0;
      end
    endcase
    if (fsm_d == FLASH) begin
      if (cur_type_d) tc2_d = SCORE_COLOR;
      else            tc1_d = MISS_COLOR;
    end
  end

  // Busy while a flash/gap is running or requests are pending.
  assign bus.busy = (fsm_q != IDLE) || (q_count != '0);

endmodule

// File: doc/led_flash_sched.md
Name: led_flash_sched

Overview:
Event scheduler for the two board tri-color LEDs. It detects changes on the game's score and miss counters and queues each change as a flash request. It then plays the requests one at a time, each as a timed flash followed by a dark gap. It sits between the game-logic counters and the LED pins, so no flash is lost or shortened when events arrive back-to-back or in the same cycle.

Parameters:
HOLD_CYCLES, 25000000, clk cycles an LED stays lit per flash (>=1)
GAP_CYCLES, 5000000, clk cycles both LEDs stay dark between flashes (>=1)
PLAY_STATE, 3'd2, game state code during which events are captured
MISS_COLOR, 3'b100, tri_color1 pattern for a miss flash
SCORE_COLOR, 3'b011, tri_color2 pattern for a score flash

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous active-low reset
state  input  3  current game state code
score  input  4  game score counter
miss  input  4  game miss counter
tri_color1  output  3  miss LED drive, registered
tri_color2  output  3  score LED drive, registered
busy  output  1  high when the FSM is not IDLE or the queue is non-empty
overflow  output  1  sticky; set when an event is dropped because the queue is full

Behaviour:
- Reset (rst low, async): tri_color1=0, tri_color2=0, busy=0, overflow=0, queue empty, FSM=IDLE, counter=0, score_q=0, miss_q=0, primed=0.
- Priming: on the first posedge after reset release, load score_q<=score and miss_q<=miss, set primed=1, and generate no events.
- Change detection (primed=1): at each posedge, score_ev=(score!=score_q) and miss_ev=(miss!=miss_q). score_q and miss_q always reload from the inputs, so one change gives one event regardless of step size or direction, including 4'hF->0 wrap.
- Events are pushed only when state==PLAY_STATE. Outside PLAY_STATE, score_q and miss_q still track the inputs, but nothing is pushed.
- Queue: 4-entry FIFO of 1-bit type (0=miss, 1=score) with 3-bit count, and push and pop allowed in the same cycle.
  - Simultaneous miss_ev and score_ev: push miss first, then score (two entries in one cycle).
  - Events that do not fit are dropped, newest first, and overflow<=1 is set.
  - Free space is computed after any pop in the same cycle.
- FSM states:
  - IDLE: both outputs 0. If the queue is non-empty, pop the head, go to FLASH, and set counter=HOLD_CYCLES-1.
  - FLASH: drive MISS_COLOR on tri_color1 (type 0) or SCORE_COLOR on tri_color2 (type 1); the other output is 0. Decrement the counter each cycle. At counter==0, go to GAP, set counter=GAP_CYCLES-1, and both outputs go to 0.
  - GAP: both outputs 0. Decrement the counter. At counter==0: if the queue is non-empty, pop and go straight to FLASH; else go to IDLE.
- Latency and timing:
  - A counter change sampled at edge k is queued at edge k; the LED is lit after edge k+1 if the FSM was IDLE.
  - Each flash lasts exactly HOLD_CYCLES cycles and each gap exactly GAP_CYCLES cycles.
  - Back-to-back queued events have no extra IDLE cycle.
- State leaving PLAY_STATE does not abort a flash in progress or flush the queue. Queued events still play out.
- Reset mid-flash: outputs go to 0 immediately (async) and the queue is cleared.
- overflow clears only on reset.
- busy is combinational from FSM!=IDLE || count!=0.

Test Plan:
- Settings HOLD_CYCLES=4, GAP_CYCLES=2, PLAY_STATE=2 for all scenarios.
- Reset with score=5, miss=3, release, hold inputs for 10 cycles -> no flash, busy=0, outputs 0 throughout (priming suppresses a false event).
- state=2, score 0->1 at edge k -> tri_color2=3'b011 for exactly 4 cycles starting after edge k+1, then 2 dark cycles, then IDLE with busy=0.
- state=2, score and miss change in the same cycle -> tri_color1=3'b100 for 4 cycles, 2 dark, then tri_color2=3'b011 for 4 cycles, with no IDLE cycle in between.
- state=2, six score changes on consecutive cycles -> 1 goes directly into FLASH, 4 are queued, 1 is dropped. Expect 5 score flashes total and overflow=1, which stays set until rst.
- state=0, miss changes -> no flash. Then state=2 with no further change -> still no flash (score_q/miss_q tracked while out of PLAY_STATE).
- rst asserted during the 2nd cycle of a flash with 2 events queued -> outputs 0 immediately. After release, no pending flashes play and overflow=0.
